// File: rtl/mirfak_fetch_pkg.sv
// mirfak_fetch_pkg: shared NOP, fault cause codes and fetch FSM state encodings
package mirfak_fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS_FAULT = 4'd1;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_ABORT} fetch_state_e;
endpackage

// File: rtl/mirfak_fetch.sv
// mirfak_fetch: single-outstanding Wishbone instruction fetch with redirect/abort handling
// Optional fault reporting (err, misaligned targets) under MIRFAK_IFETCH_FAULT_EN
module mirfak_fetch
  import mirfak_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instruction_o,
  output logic        if_exception_o,
  output logic [3:0]  if_exc_cause_o,
  output logic        if_ready_o,
  input  logic        ifid_enable_i,
  input  logic        id_bj_taken_i,
  input  logic [31:0] id_target_i,
  input  logic        wb_exception_i,
  input  logic        wb_xret_i,
  input  logic [31:0] wb_target_i
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, inst_q, inst_d, ifpc_q, ifpc_d, tgt, start_pc;
  logic [3:0] cause_q, cause_d;
  logic cyc_q, ready_q, exc_q, exc_d, start, start_mis, redir, resp;
  assign redir = wb_exception_i | wb_xret_i | id_bj_taken_i;
  assign resp = iport_ack_i | iport_err_i;
`ifdef MIRFAK_IFETCH_FAULT_EN
  assign tgt = (wb_exception_i | wb_xret_i) ? wb_target_i : id_target_i;
  assign start_mis = |start_pc[1:0];
`else
  assign tgt = ((wb_exception_i | wb_xret_i) ? wb_target_i : id_target_i) & ~32'h3;
  assign start_mis = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    inst_d = inst_q;
    ifpc_d = ifpc_q;
    exc_d = exc_q;
    cause_d = cause_q;
    start = 1'b0;
    start_pc = pc_q;
    case (state_q)
      ST_IDLE: start = 1'b1;
      ST_FETCH: begin
        if (redir) begin
          pc_d = tgt;
          start = resp;
          start_pc = tgt;
          state_d = resp ? ST_FETCH : ST_ABORT;
        end else if (resp) begin
          state_d = ST_HOLD;
          ifpc_d = pc_q;
          inst_d = iport_err_i ? NOP_INSTR : iport_data_i;
`ifdef MIRFAK_IFETCH_FAULT_EN
          exc_d = iport_err_i;
          cause_d = iport_err_i ? CAUSE_ACCESS_FAULT : CAUSE_MISALIGNED;
`else
          exc_d = 1'b0;
          cause_d = CAUSE_MISALIGNED;
`endif
        end
      end
      ST_ABORT: begin
        pc_d = redir ? tgt : pc_q;
        start = resp;
        start_pc = pc_d;
      end
      default: begin
        pc_d = redir ? tgt : ifid_enable_i ? pc_q + 32'd4 : pc_q;
        start = redir | ifid_enable_i;
        start_pc = pc_d;
      end
    endcase
    // a misaligned start never reaches the bus; it becomes a faulted held entry
    if (start && start_mis) begin
      state_d = ST_HOLD;
      exc_d = 1'b1;
      cause_d = CAUSE_MISALIGNED;
      inst_d = NOP_INSTR;
      ifpc_d = start_pc;
    end else if (start) begin
      state_d = ST_FETCH;
      addr_d = start_pc;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pc_q <= RESET_ADDR;
      addr_q <= RESET_ADDR;
      cyc_q <= 1'b0;
      ready_q <= 1'b0;
      inst_q <= NOP_INSTR;
      exc_q <= 1'b0;
      cause_q <= CAUSE_MISALIGNED;
      ifpc_q <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      cyc_q <= (state_d == ST_FETCH) || (state_d == ST_ABORT);
      ready_q <= state_d == ST_HOLD;
      inst_q <= inst_d;
      exc_q <= exc_d;
      cause_q <= cause_d;
      ifpc_q <= ifpc_d;
    end
  end
  assign iport_addr_o = addr_q;
  assign iport_cyc_o = cyc_q;
  assign iport_stb_o = cyc_q;
  assign if_pc_o = ifpc_q;
  assign if_instruction_o = inst_q;
  assign if_exception_o = exc_q;
  assign if_exc_cause_o = cause_q;
  assign if_ready_o = ready_q;
endmodule

// File: tb/tb_mirfak_fetch.sv
// tb_mirfak_fetch: directed checks of reset, wait states, hold, redirect/abort, wrap and faults
module tb_mirfak_fetch;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [31:0] iport_addr_o, iport_data_i, if_pc_o, if_instruction_o, id_target_i, wb_target_i;
  logic iport_cyc_o, iport_stb_o, iport_ack_i, iport_err_i, if_exception_o, if_ready_o;
  logic ifid_enable_i, id_bj_taken_i, wb_exception_i, wb_xret_i;
  logic [3:0] if_exc_cause_o;
  int checks = 0;
  int errors = 0;
  always #5 clk_i = ~clk_i;
  mirfak_fetch dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .iport_addr_o(iport_addr_o), .iport_cyc_o(iport_cyc_o), .iport_stb_o(iport_stb_o),
    .iport_data_i(iport_data_i), .iport_ack_i(iport_ack_i), .iport_err_i(iport_err_i),
    .if_pc_o(if_pc_o), .if_instruction_o(if_instruction_o), .if_exception_o(if_exception_o),
    .if_exc_cause_o(if_exc_cause_o), .if_ready_o(if_ready_o), .ifid_enable_i(ifid_enable_i),
    .id_bj_taken_i(id_bj_taken_i), .id_target_i(id_target_i), .wb_exception_i(wb_exception_i),
    .wb_xret_i(wb_xret_i), .wb_target_i(wb_target_i)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk_bus(input string tag, input logic cyc, input logic [31:0] addr, input logic rdy);
    chk({tag, ".cyc"}, {31'd0, iport_cyc_o}, {31'd0, cyc});
    chk({tag, ".stb"}, {31'd0, iport_stb_o}, {31'd0, cyc});
    chk({tag, ".addr"}, iport_addr_o, addr);
    chk({tag, ".rdy"}, {31'd0, if_ready_o}, {31'd0, rdy});
  endtask
  task automatic chk_held(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic exc, input logic [3:0] cause);
    chk({tag, ".pc"}, if_pc_o, pc);
    chk({tag, ".ins"}, if_instruction_o, ins);
    chk({tag, ".exc"}, {31'd0, if_exception_o}, {31'd0, exc});
    chk({tag, ".cause"}, {28'd0, if_exc_cause_o}, {28'd0, cause});
  endtask
  initial begin
    iport_data_i = 32'h0; iport_ack_i = 0; iport_err_i = 0; ifid_enable_i = 0;
    id_bj_taken_i = 0; id_target_i = 32'h0; wb_exception_i = 0; wb_xret_i = 0; wb_target_i = 32'h0;
    step(); step();
    chk_bus("rst", 0, 32'h8000_0000, 0);
    chk_held("rst", 32'h8000_0000, 32'h13, 0, 4'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bus("ws", 1, 32'h8000_0000, 0);
      if (i == 2) begin iport_ack_i = 1; iport_data_i = 32'hDEAD_BEEF; end
    end
    step();
    iport_ack_i = 0;
    chk_bus("ack0", 0, 32'h8000_0000, 1);
    chk_held("ack0", 32'h8000_0000, 32'hDEAD_BEEF, 0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_bus("hold", 0, 32'h8000_0000, 1);
      chk("hold.ins", if_instruction_o, 32'hDEAD_BEEF);
    end
    ifid_enable_i = 1;
    step();
    ifid_enable_i = 0;
    chk_bus("next", 1, 32'h8000_0004, 0);
    id_bj_taken_i = 1; id_target_i = 32'h8000_0100;
    step();
    id_bj_taken_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk_bus("abort", 1, 32'h8000_0004, 0);
      if (i == 2) begin iport_ack_i = 1; iport_data_i = 32'h1111_1111; end
      else step();
    end
    step();
    chk_bus("abort.out", 1, 32'h8000_0100, 0);
    iport_data_i = 32'h2222_2222;
    step();
    iport_ack_i = 0;
    chk_bus("tgt.ack", 0, 32'h8000_0100, 1);
    chk_held("tgt.ack", 32'h8000_0100, 32'h2222_2222, 0, 4'd0);
    wb_exception_i = 1; wb_target_i = 32'h8000_0200; id_bj_taken_i = 1; id_target_i = 32'h8000_0300;
    step();
    wb_exception_i = 0; id_bj_taken_i = 0;
    chk_bus("prio", 1, 32'h8000_0200, 0);
    iport_err_i = 1; iport_data_i = 32'h5A5A_5A5A;
    step();
    iport_err_i = 0;
    chk_bus("err", 0, 32'h8000_0200, 1);
`ifdef MIRFAK_IFETCH_FAULT_EN
    chk_held("err", 32'h8000_0200, 32'h13, 1, 4'd1);
    wb_xret_i = 1; wb_target_i = 32'h8000_0102;
    step();
    wb_xret_i = 0;
    chk_bus("mis", 0, 32'h8000_0200, 1);
    chk_held("mis", 32'h8000_0102, 32'h13, 1, 4'd0);
`else
    chk_held("err", 32'h8000_0200, 32'h13, 0, 4'd0);
    wb_xret_i = 1; wb_target_i = 32'h8000_0102;
    step();
    wb_xret_i = 0;
    chk_bus("mis", 1, 32'h8000_0100, 0);
    iport_ack_i = 1; iport_data_i = 32'h5555_5555;
    step();
    iport_ack_i = 0;
    chk_held("mis.ack", 32'h8000_0100, 32'h5555_5555, 0, 4'd0);
`endif
    id_bj_taken_i = 1; id_target_i = 32'h8000_0400;
    step();
    id_bj_taken_i = 0;
    chk_bus("bj.hold", 1, 32'h8000_0400, 0);
    iport_ack_i = 1; iport_data_i = 32'h4444_4444; id_bj_taken_i = 1; id_target_i = 32'h8000_0500;
    step();
    iport_ack_i = 0; id_bj_taken_i = 0;
    chk_bus("ack.redir", 1, 32'h8000_0500, 0);
    iport_ack_i = 1; wb_xret_i = 1; wb_target_i = 32'hFFFF_FFFC;
    step();
    wb_xret_i = 0;
    chk_bus("xret", 1, 32'hFFFF_FFFC, 0);
    iport_data_i = 32'h6666_6666;
    step();
    iport_ack_i = 0;
    chk_held("top", 32'hFFFF_FFFC, 32'h6666_6666, 0, 4'd0);
    ifid_enable_i = 1;
    step();
    ifid_enable_i = 0;
    chk_bus("wrap", 1, 32'h0000_0000, 0);
    rst_ni = 0;
    #1;
    chk_bus("arst", 0, 32'h8000_0000, 0);
    iport_ack_i = 1; iport_data_i = 32'h7777_7777;
    step();
    iport_ack_i = 0;
    rst_ni = 1;
    step();
    chk_bus("rel", 1, 32'h8000_0000, 0);
    chk_held("rel", 32'h8000_0000, 32'h13, 0, 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
